regfile_wb_arbiter: RTL

- Shares the single write port of the 8 x 16-bit register file between two writeback requesters: requester 0 is the ALU result and requester 1 is the memory/load result.
- Grants at most one requester per cycle, using round-robin or fixed priority.
- Registers the granted write into an output stage that drives the register file's regWrite/writeReg/writeData directly.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register-file writeback path.
//   DATA_W / ADDR_W / NUM_REGS : register file geometry (8 x 16-bit)
//   REG_ZERO                   : hardwired-zero register index
//   GNT_ALU / GNT_MEM          : grant-id encodings for the two requesters
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam logic [2:0] REG_ZERO = 3'd0;

  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input writeback grant logic with a last-grant register.
// Ports:
//   clk, reset_n      : clock and asynchronous active-low reset
//   stall             : suppresses all grants while high
//   valid0, valid1    : request valids (0 = ALU, 1 = memory/load)
//   gnt0, gnt1        : combinational one-hot (or zero) grants
// FIXED_PRIO = 0 alternates on conflict; FIXED_PRIO = 1 always favours 0.
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant_r;
  logic gnt0_s;
  logic gnt1_s;

  // Grant selection from current valids, stall and previous winner.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (stall) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (valid0 && valid1) begin
      if (FIXED_PRIO != 0) begin
        gnt0_s = 1'b1;
      end else if (last_grant_r == GNT_MEM) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else begin
      gnt0_s = valid0;
      gnt1_s = valid1;
    end
  end

  // Remember the winner of each transfer; reset favours requester 0 first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= GNT_MEM;
    end else if (gnt0_s) begin
      last_grant_r <= GNT_ALU;
    end else if (gnt1_s) begin
      last_grant_r <= GNT_MEM;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign gnt0 = gnt0_s;
  assign gnt1 = gnt1_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// (requester 0) and the load path (requester 1), registering the granted
// write into an output stage that drives regWrite/writeReg/writeData.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   stall_i                      : blocks grants, output stage goes idle
//   req0_* / req1_*              : valid/addr/data in, ready (grant) out
//   rf_we, rf_addr, rf_data      : registered write to the register file
//   grant_id                     : which requester produced rf_*
//   conflict_cnt                 : saturating count of both-valid cycles
// Optional (macro REGFILE_WB_FWD_EN): fwd_raddr1/2 in, fwd_hit1/2 and
// fwd_data out, for decode to bypass the write in flight.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
`ifdef REGFILE_WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_raddr1,
  input  logic [ADDR_W-1:0] fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              grant_id,
  output logic [7:0]        conflict_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              gnt0_s;
  logic              gnt1_s;
  logic              xfer_s;
  logic              sel_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              conflict_s;

  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_addr_r;
  logic [DATA_W-1:0] rf_data_r;
  logic              grant_id_r;
  logic [7:0]        conflict_cnt_r;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .stall  (stall_i),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt0   (gnt0_s),
    .gnt1   (gnt1_s)
  );

  // Mux the granted request toward the output stage.
  always_comb begin
    xfer_s     = gnt0_s | gnt1_s;
    sel_s      = GNT_ALU;
    wr_addr_s  = req0_addr;
    wr_data_s  = req0_data;
    conflict_s = req0_valid & req1_valid & ~stall_i;
    if (gnt1_s) begin
      sel_s     = GNT_MEM;
      wr_addr_s = req1_addr;
      wr_data_s = req1_data;
    end else begin
      sel_s     = GNT_ALU;
      wr_addr_s = req0_addr;
      wr_data_s = req0_data;
    end
  end

  // Output stage: capture the transfer; writes to r0 are accepted but dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_r    <= 1'b0;
      rf_addr_r  <= '0;
      rf_data_r  <= '0;
      grant_id_r <= GNT_ALU;
    end else if (xfer_s) begin
      rf_we_r    <= (wr_addr_s != ZERO_IDX);
      rf_addr_r  <= wr_addr_s;
      rf_data_r  <= wr_data_s;
      grant_id_r <= sel_s;
    end else begin
      rf_we_r    <= 1'b0;
      rf_addr_r  <= rf_addr_r;
      rf_data_r  <= rf_data_r;
      grant_id_r <= grant_id_r;
    end
  end

  // Saturating conflict counter; stalled cycles do not count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt_r <= 8'd0;
    end else if (conflict_s && (conflict_cnt_r != 8'hFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 8'd1;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign req0_ready   = gnt0_s;
  assign req1_ready   = gnt1_s;
  assign rf_we        = rf_we_r;
  assign rf_addr      = rf_addr_r;
  assign rf_data      = rf_data_r;
  assign grant_id     = grant_id_r;
  assign conflict_cnt = conflict_cnt_r;

`ifdef REGFILE_WB_FWD_EN
  // r0 never forwards: its reads are hardwired to zero in the register file.
  assign fwd_hit1 = rf_we_r && (rf_addr_r == fwd_raddr1) && (fwd_raddr1 != ZERO_IDX);
  assign fwd_hit2 = rf_we_r && (rf_addr_r == fwd_raddr2) && (fwd_raddr2 != ZERO_IDX);
  assign fwd_data = rf_data_r;
`endif

endmodule
